// File: rtl/pix_stream_checker.sv
// Pixel stream checker: drains one frame from an AFIFO read port, compares it against
// a generated pattern, then watches a tail window for extra data. Option: PIX_STREAM_CHECKER_ERRLOG_EN.
module pix_stream_checker #(
    parameter int          W          = 16,
    parameter int          PixelCount = 2304 * 1296,
    parameter int          Mode       = 0,
    parameter logic [15:0] LfsrTaps   = 16'hB400,
    parameter int          LfsrSeed   = 1,
    parameter int          TailCycles = 16,
    localparam int         PixW       = $clog2(PixelCount + 1),
    localparam int         RemW       = (PixelCount > 1) ? $clog2(PixelCount) : 1,
    localparam int         TailW      = (TailCycles > 1) ? $clog2(TailCycles) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic            r_ready,
    output logic            r_trigger,
    input  logic [W-1:0]    r_data,
    output logic            err_mismatch,
    output logic            err_extra,
    output logic            err_short,
    output logic [15:0]     err_count,
    output logic [PixW-1:0] pix_count
`ifdef PIX_STREAM_CHECKER_ERRLOG_EN
    ,
    output logic [PixW-1:0] err_first_idx,
    output logic [W-1:0]    err_first_exp,
    output logic [W-1:0]    err_first_got
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_TAIL,
        S_REPORT
    } state_t;

    localparam logic [W-1:0] TapsW    = W'(LfsrTaps);
    localparam logic [W-1:0] ExpFirst = (Mode == 0) ? W'(PixelCount - 1) :
                                        (Mode == 1) ? '0 : W'(LfsrSeed);

    state_t          state_q, state_d;
    logic [RemW-1:0] remain_q;
    logic [W-1:0]    exp_q;
    logic [TailW-1:0] tail_q;
    logic            xfer;
    logic            tail_last;

    function automatic logic [W-1:0] next_exp(input logic [W-1:0] cur);
        if (Mode == 0)
            return cur - 1'b1;
        else if (Mode == 1)
            return cur + 1'b1;
        else
            return (cur >> 1) ^ (cur[0] ? TapsW : '0);
    endfunction

    assign xfer      = r_trigger && r_ready;
    assign tail_last = (tail_q == TailW'(TailCycles - 1));
    assign err_short = 1'b0;

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (xfer && remain_q == '0) state_d = S_TAIL;
            end
            S_TAIL: begin
                busy = 1'b1;
                if (tail_last) state_d = S_REPORT;
            end
            S_REPORT: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            r_trigger    <= 1'b0;
            remain_q     <= '0;
            exp_q        <= '0;
            tail_q       <= '0;
            err_mismatch <= 1'b0;
            err_extra    <= 1'b0;
            err_count    <= '0;
            pix_count    <= '0;
`ifdef PIX_STREAM_CHECKER_ERRLOG_EN
            err_first_idx <= '0;
            err_first_exp <= '0;
            err_first_got <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        err_mismatch <= 1'b0;
                        err_extra    <= 1'b0;
                        err_count    <= '0;
                        pix_count    <= '0;
                        remain_q     <= RemW'(PixelCount - 1);
                        exp_q        <= ExpFirst;
                        r_trigger    <= 1'b1;
`ifdef PIX_STREAM_CHECKER_ERRLOG_EN
                        err_first_idx <= '0;
                        err_first_exp <= '0;
                        err_first_got <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (r_data != exp_q) begin
                            err_mismatch <= 1'b1;
                            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`ifdef PIX_STREAM_CHECKER_ERRLOG_EN
                            // Only the first mismatch of the frame is logged.
                            if (!err_mismatch) begin
                                err_first_idx <= pix_count;
                                err_first_exp <= exp_q;
                                err_first_got <= r_data;
                            end
`ifdef SIM
                            $display("pix_stream_checker: pixel %0d expected %0h got %0h",
                                     pix_count, exp_q, r_data);
`endif
`endif
                        end
                        pix_count <= pix_count + 1'b1;
                        exp_q     <= next_exp(exp_q);
                        if (remain_q == '0) begin
                            r_trigger <= 1'b0;
                            tail_q    <= '0;
                        end else begin
                            remain_q <= remain_q - 1'b1;
                        end
                    end
                end
                S_TAIL: begin
                    if (r_ready) err_extra <= 1'b1;
                    tail_q <= tail_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pix_stream_checker.sv
// Directed bench for pix_stream_checker: three instances (descending, ascending, LFSR)
// share one stimulus port set, selected by sel.
module tb_pix_stream_checker;

    localparam int W  = 16;
    localparam int PC = 8;
    localparam int TC = 16;
    localparam int PW = $clog2(PC + 1);

    logic          clk = 1'b0;
    logic          rst, start, r_ready;
    logic [W-1:0]  r_data;
    int            sel;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;

    logic [2:0]    start_v, rdy_v, busy_v, done_v, trig_v, mis_v, ext_v, sht_v;
    logic [15:0]   ecnt_v [3];
    logic [PW-1:0] pcnt_v [3];

    logic          busy_m, done_m, trig_m, mis_m, ext_m, sht_m;
    logic [15:0]   ecnt_m;
    logic [PW-1:0] pcnt_m;

    logic [W-1:0]  desc_v [8] = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd0};
    logic [W-1:0]  bad_v  [8] = '{16'd7, 16'd6, 16'd5, 16'd9, 16'd3, 16'd2, 16'd1, 16'd0};
    logic [W-1:0]  asc_v  [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    logic [W-1:0]  lfsr_v [8] = '{16'h0001, 16'hB400, 16'h5A00, 16'h2D00,
                                  16'h1680, 16'h0B40, 16'h05A0, 16'h02D0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        assign start_v[k] = start && (sel == k);
        assign rdy_v[k]   = r_ready && (sel == k);
        pix_stream_checker #(
            .W(W), .PixelCount(PC), .Mode(k), .LfsrTaps(16'hB400),
            .LfsrSeed(1), .TailCycles(TC)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start_v[k]),
            .busy        (busy_v[k]),
            .done        (done_v[k]),
            .r_ready     (rdy_v[k]),
            .r_trigger   (trig_v[k]),
            .r_data      (r_data),
            .err_mismatch(mis_v[k]),
            .err_extra   (ext_v[k]),
            .err_short   (sht_v[k]),
            .err_count   (ecnt_v[k]),
            .pix_count   (pcnt_v[k])
        );
    end

    always_comb begin
        busy_m = busy_v[sel];
        done_m = done_v[sel];
        trig_m = trig_v[sel];
        mis_m  = mis_v[sel];
        ext_m  = ext_v[sel];
        sht_m  = sht_v[sel];
        ecnt_m = ecnt_v[sel];
        pcnt_m = pcnt_v[sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after acceptance.
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("trigger_after_start", 32'(trig_m), 32'd1);
        check("busy_after_start", 32'(busy_m), 32'd1);
    endtask

    task automatic run_frame(input logic [W-1:0] vals [8], input int nwords, input bit toggle,
                             input int start_at, output int first_c, output int last_c);
        int  n = 0;
        bit  rdy;
        bit  pulsed = 1'b0;
        first_c = -1;
        last_c  = -1;
        for (int g = 0; g < 100 && n < nwords; g++) begin
            rdy     = toggle ? (g % 2 == 0) : 1'b1;
            r_ready = rdy;
            r_data  = vals[n];
            start   = (n == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            if (toggle && !rdy) check("trigger_hold", 32'(trig_m), 32'd1);
            if (trig_m && rdy) begin
                if (n == 0) first_c = cyc;
                last_c = cyc;
                n++;
            end
            @(negedge clk);
        end
        r_ready = 1'b0;
        start   = 1'b0;
        check("transfers", 32'(n), 32'(nwords));
    endtask

    task automatic wait_done(input int last_c, input string tag);
        bit seen = 1'b0;
        int dc = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            if (done_m) begin
                seen = 1'b1;
                dc   = cyc;
                check({tag, "_busy_at_done"}, 32'(busy_m), 32'd0);
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_done_latency"}, 32'(dc - last_c), 32'(TC + 1));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_m), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int f, l, dones;
        rst = 1'b1; start = 1'b0; r_ready = 1'b0; r_data = '0; sel = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_m), 32'd0);
        check("rst_done", 32'(done_m), 32'd0);
        check("rst_trigger", 32'(trig_m), 32'd0);
        check("rst_errs", {29'd0, mis_m, ext_m, sht_m}, 32'd0);
        check("rst_err_count", 32'(ecnt_m), 32'd0);
        check("rst_pix_count", 32'(pcnt_m), 32'd0);
        rst = 1'b0;

        // Clean descending frame, back-to-back transfers.
        sel = 0;
        do_start();
        run_frame(desc_v, 8, 1'b0, -1, f, l);
        check("desc_consecutive", 32'(l - f), 32'd7);
        check("desc_tail_trigger", 32'(trig_m), 32'd0);
        wait_done(l, "desc");
        check("desc_errs", {29'd0, mis_m, ext_m, sht_m}, 32'd0);
        check("desc_err_count", 32'(ecnt_m), 32'd0);
        check("desc_pix_count", 32'(pcnt_m), 32'd8);

        // One corrupted pixel.
        do_start();
        run_frame(bad_v, 8, 1'b0, -1, f, l);
        wait_done(l, "mis");
        check("mis_flag", 32'(mis_m), 32'd1);
        check("mis_err_count", 32'(ecnt_m), 32'd1);
        check("mis_extra", 32'(ext_m), 32'd0);
        check("mis_pix_count", 32'(pcnt_m), 32'd8);

        // A ninth word during the tail window; start also clears previous errors.
        do_start();
        check("clr_mismatch", 32'(mis_m), 32'd0);
        check("clr_err_count", 32'(ecnt_m), 32'd0);
        check("clr_pix_count", 32'(pcnt_m), 32'd0);
        run_frame(desc_v, 8, 1'b0, -1, f, l);
        check("extra_before", 32'(ext_m), 32'd0);
        r_ready = 1'b1;
        r_data  = 16'hFFFF;
        @(negedge clk);
        r_ready = 1'b0;
        check("extra_flag", 32'(ext_m), 32'd1);
        wait_done(l, "extra");
        check("extra_mismatch", 32'(mis_m), 32'd0);
        check("extra_held", 32'(ext_m), 32'd1);

        // Ascending pattern with r_ready toggling.
        sel = 1;
        do_start();
        run_frame(asc_v, 8, 1'b1, -1, f, l);
        check("asc_span", 32'(l - f), 32'd14);
        wait_done(l, "asc");
        check("asc_errs", {29'd0, mis_m, ext_m, sht_m}, 32'd0);
        check("asc_pix_count", 32'(pcnt_m), 32'd8);

        // LFSR pattern with a start pulse in the middle of the frame.
        sel = 2;
        do_start();
        run_frame(lfsr_v, 8, 1'b0, 3, f, l);
        check("lfsr_consecutive", 32'(l - f), 32'd7);
        wait_done(l, "lfsr");
        check("lfsr_err_count", 32'(ecnt_m), 32'd0);
        check("lfsr_mismatch", 32'(mis_m), 32'd0);
        check("lfsr_pix_count", 32'(pcnt_m), 32'd8);

        // Reset mid-frame, then a clean frame.
        sel = 0;
        do_start();
        run_frame(desc_v, 3, 1'b0, -1, f, l);
        check("mid_pix_count", 32'(pcnt_m), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_busy", 32'(busy_m), 32'd0);
        check("mrst_trigger", 32'(trig_m), 32'd0);
        check("mrst_pix_count", 32'(pcnt_m), 32'd0);
        dones = 0;
        repeat (25) begin
            if (done_m) dones++;
            @(negedge clk);
        end
        check("mrst_no_done", 32'(dones), 32'd0);
        do_start();
        run_frame(desc_v, 8, 1'b0, -1, f, l);
        wait_done(l, "post");
        check("post_errs", {29'd0, mis_m, ext_m, sht_m}, 32'd0);
        check("post_pix_count", 32'(pcnt_m), 32'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
